// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: controller state encoding, forwarding selects and counter sizing
package pipe_hazard_ctrl_pkg;
   typedef enum logic [1:0] {RUN, MDU, DRAIN, HALT} state_e;
   localparam logic [1:0] FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10;
   function automatic int cnt_width(int a, int b);
      return $clog2(a > b ? a : b);
   endfunction
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle
interface pipe_hazard_ctrl_if;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic       ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MduStartE, halt_req, resume;
   logic       StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_done, halted;
   logic [1:0] ForwardAE, ForwardBE;
   modport master (
      output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      output ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MduStartE, halt_req, resume,
      input  StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_done, halted, ForwardAE, ForwardBE
   );
   modport slave (
      input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
      input  ResultSrcE0, RegWriteM, RegWriteW, PCSrcE, MduStartE, halt_req, resume,
      output StallF, StallD, StallE, FlushD, FlushE, FlushM, mdu_done, halted, ForwardAE, ForwardBE
   );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// fwd_unit: selects the forwarding source for one Execute operand, Memory beating Writeback
module fwd_unit
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic [4:0] rs_i,
   input  logic [4:0] rd_m_i,
   input  logic [4:0] rd_w_i,
   input  logic       reg_write_m_i,
   input  logic       reg_write_w_i,
   output logic [1:0] fwd_o
);
   always_comb fwd_o = (reg_write_m_i && rd_m_i != '0 && rd_m_i == rs_i) ? FWD_MEM :
                       (reg_write_w_i && rd_w_i != '0 && rd_w_i == rs_i) ? FWD_WB : FWD_RF;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control with MDU sequencing and debug halt/drain/resume
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MDU_CYCLES   = 4,
   parameter int DRAIN_CYCLES = 3
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int CW = cnt_width(MDU_CYCLES, DRAIN_CYCLES);
   localparam logic [CW-1:0] MDU_LOAD   = CW'(MDU_CYCLES - 2);
   localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          halt_pend_q, halt_pend_d;
   logic          lw_stall, mdu_start, hold, cnt_zero, run, drain;

   fwd_unit u_fwd_a (
      .rs_i(bus.Rs1E), .rd_m_i(bus.RdM), .rd_w_i(bus.RdW),
      .reg_write_m_i(bus.RegWriteM), .reg_write_w_i(bus.RegWriteW), .fwd_o(bus.ForwardAE)
   );
   fwd_unit u_fwd_b (
      .rs_i(bus.Rs2E), .rd_m_i(bus.RdM), .rd_w_i(bus.RdW),
      .reg_write_m_i(bus.RegWriteM), .reg_write_w_i(bus.RegWriteW), .fwd_o(bus.ForwardBE)
   );

   assign run       = state_q == RUN;
   assign drain     = state_q == DRAIN;
   assign cnt_zero  = cnt_q == '0;
   assign lw_stall  = bus.ResultSrcE0 && bus.RdE != '0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
   // an MDU op freezes the front end and feeds bubbles into Memory until its last cycle
   assign mdu_start = (run || drain) && bus.MduStartE;
   assign hold      = mdu_start || (state_q == MDU && !cnt_zero);

   assign bus.StallE   = hold;
   assign bus.FlushM   = hold;
   assign bus.StallD   = hold || (run && lw_stall);
   assign bus.StallF   = hold || (run && lw_stall) || (drain && !bus.PCSrcE) || state_q == HALT;
   assign bus.FlushD   = !hold && ((run && bus.PCSrcE) || drain || state_q == HALT);
   assign bus.FlushE   = !hold && (((run || drain) && bus.PCSrcE) || (run && lw_stall));
   assign bus.mdu_done = state_q == MDU && cnt_zero;
   assign bus.halted   = state_q == HALT;

   always_comb begin
      state_d = mdu_start        ? MDU
              : run              ? (halt_pend_q ? DRAIN : RUN)
              : state_q == MDU   ? (!cnt_zero ? MDU : halt_pend_q ? DRAIN : RUN)
              : drain            ? (cnt_zero ? HALT : DRAIN)
              : (bus.resume ? RUN : HALT);
      cnt_d = mdu_start          ? MDU_LOAD
            : state_q == HALT    ? cnt_q
            : (run || cnt_zero)  ? DRAIN_LOAD
            : cnt_q - 1'b1;
      halt_pend_d = (state_q == HALT && bus.resume) ? 1'b0
                  : halt_pend_q || (bus.halt_req && state_q != HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         halt_pend_q <= halt_pend_d;
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, directed multi-cycle sequences and randomized model check
module tb_pipe_hazard_ctrl;
   localparam int MDU = 4, DRN = 3;
   localparam logic [5:0] HOLD = 6'b111001, DRAINO = 6'b100100, BRDRAIN = 6'b000110;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0, n_fail = 0;
   int   m_busy, m_drain;
   bit   m_halted, m_pend, hreq;

   pipe_hazard_ctrl_if bus();
   pipe_hazard_ctrl #(.MDU_CYCLES(MDU), .DRAIN_CYCLES(DRN)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   typedef struct {
      int rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw, lw, rwm, rww, pc, fa, fb, ctl;
   } vec_t;
   vec_t vecs[11];

   function automatic logic [11:0] got_o();
      return {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM,
              bus.ForwardAE, bus.ForwardBE, bus.mdu_done, bus.halted};
   endfunction

   function automatic logic [11:0] e(logic [5:0] ctl, logic done, logic hlt);
      return {ctl, 4'b0000, done, hlt};
   endfunction

   task automatic check(string name, logic [11:0] exp);
      logic [11:0] got;
      got = got_o();
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (SF SD SE FD FE FM FA FB done halted)", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic look(string name, logic [11:0] exp);
      @(negedge clk);
      check(name, exp);
   endtask

   task automatic idle();
      {bus.Rs1D, bus.Rs2D, bus.Rs1E, bus.Rs2E, bus.RdE, bus.RdM, bus.RdW} = '0;
      {bus.ResultSrcE0, bus.RegWriteM, bus.RegWriteW, bus.PCSrcE, bus.MduStartE} = '0;
      bus.halt_req = 1'b0;
      bus.resume   = 1'b0;
   endtask

   function automatic logic [1:0] fwd_ref(logic [4:0] rs);
      if (bus.RegWriteM && bus.RdM != 0 && bus.RdM == rs) return 2'b10;
      if (bus.RegWriteW && bus.RdW != 0 && bus.RdW == rs) return 2'b01;
      return 2'b00;
   endfunction

   // reference: an MDU op is a count of Execute cycles left, draining a count of bubbles left
   task automatic model_cycle(int cyc);
      logic [5:0] c;
      logic       done, lws, pc;
      bit         new_pend;
      pc  = bus.PCSrcE;
      lws = bus.ResultSrcE0 && bus.RdE != 0 && (bus.RdE == bus.Rs1D || bus.RdE == bus.Rs2D);
      c = '0;
      done = 1'b0;
      if (m_halted) c = DRAINO;
      else if (m_busy > 1) c = HOLD;
      else if (m_busy == 1) done = 1'b1;
      else if (bus.MduStartE) c = HOLD;
      else if (m_drain > 0) c = {~pc, 2'b00, 1'b1, pc, 1'b0};
      else c = {lws, lws, 1'b0, pc, lws | pc, 1'b0};
      @(negedge clk);
      check($sformatf("rand@%0d", cyc), {c, fwd_ref(bus.Rs1E), fwd_ref(bus.Rs2E), done, m_halted});
      new_pend = m_pend || (bus.halt_req && !m_halted);
      if (m_halted) begin
         if (bus.resume) begin
            m_halted = 1'b0;
            new_pend = 1'b0;
         end
      end else if (m_busy > 1) m_busy--;
      else if (m_busy == 1) begin
         m_busy = 0;
         if (m_pend) m_drain = DRN;
      end else if (bus.MduStartE) begin
         m_busy  = MDU - 1;
         m_drain = 0;
      end else if (m_drain > 0) begin
         m_drain--;
         if (m_drain == 0) m_halted = 1'b1;
      end else if (m_pend) m_drain = DRN;
      m_pend = new_pend;
      if (reset) begin
         m_busy = 0; m_drain = 0; m_halted = 1'b0; m_pend = 1'b0;
      end
   endtask

   initial begin
      vecs[0]  = '{0, 0, 5, 0, 0, 5, 5, 0, 1, 1, 0, 'b10, 'b00, 0};
      vecs[1]  = '{0, 0, 5, 0, 0, 0, 5, 0, 1, 1, 0, 'b01, 'b00, 0};
      vecs[2]  = '{0, 0, 0, 9, 0, 9, 9, 0, 0, 1, 0, 'b00, 'b01, 0};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'b00, 'b00, 0};
      vecs[4]  = '{0, 7, 0, 0, 7, 0, 0, 1, 0, 0, 0, 'b00, 'b00, 'b110010};
      vecs[5]  = '{0, 7, 0, 0, 0, 0, 0, 1, 0, 0, 0, 'b00, 'b00, 0};
      vecs[6]  = '{7, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 'b00, 'b00, 0};
      vecs[7]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b00, 'b00, 'b000110};
      vecs[8]  = '{0, 0, 12, 12, 0, 12, 12, 0, 1, 1, 0, 'b10, 'b10, 0};
      vecs[9]  = '{4, 0, 0, 0, 4, 0, 0, 1, 0, 0, 1, 'b00, 'b00, 'b110110};
      vecs[10] = '{0, 0, 3, 0, 0, 3, 3, 0, 0, 0, 0, 'b00, 'b00, 0};

      idle();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      look("reset", '0);
      step();

      foreach (vecs[i]) begin
         bus.Rs1D = 5'(vecs[i].rs1d);  bus.Rs2D = 5'(vecs[i].rs2d);
         bus.Rs1E = 5'(vecs[i].rs1e);  bus.Rs2E = 5'(vecs[i].rs2e);
         bus.RdE  = 5'(vecs[i].rde);   bus.RdM  = 5'(vecs[i].rdm);  bus.RdW = 5'(vecs[i].rdw);
         bus.ResultSrcE0 = 1'(vecs[i].lw);
         bus.RegWriteM = 1'(vecs[i].rwm);
         bus.RegWriteW = 1'(vecs[i].rww);
         bus.PCSrcE = 1'(vecs[i].pc);
         look($sformatf("vec%0d", i), {6'(vecs[i].ctl), 2'(vecs[i].fa), 2'(vecs[i].fb), 2'b00});
         step();
      end
      idle();

      bus.MduStartE = 1'b1;
      look("mdu start", e(HOLD, 0, 0));
      step();
      bus.MduStartE = 1'b0;
      for (int k = 0; k < MDU - 2; k++) begin
         look($sformatf("mdu hold%0d", k), e(HOLD, 0, 0));
         step();
      end
      look("mdu done", e('0, 1, 0));
      step();
      look("mdu back run", '0);
      step();

      for (int v = 0; v < 2; v++) begin
         bus.halt_req = 1'b1;
         look("halt req", '0);
         step();
         bus.halt_req = 1'b0;
         look("halt pend run", '0);
         step();
         for (int k = 0; k < DRN; k++) begin
            bus.PCSrcE = (v == 1 && k == 1);
            look($sformatf("drain%0d v%0d", k, v), e(bus.PCSrcE ? BRDRAIN : DRAINO, 0, 0));
            step();
         end
         bus.PCSrcE = 1'b0;
         look("halted", e(DRAINO, 0, 1));
         bus.resume = 1'b1;
         step();
         bus.resume = 1'b0;
         look("resumed", '0);
         step();
      end

      bus.MduStartE = 1'b1;
      look("mdu2 start", e(HOLD, 0, 0));
      step();
      bus.MduStartE = 1'b0;
      look("mdu2 cnt2", e(HOLD, 0, 0));
      step();
      reset = 1'b1;
      look("mdu2 cnt1", e(HOLD, 0, 0));
      step();
      reset = 1'b0;
      look("mdu reset run", '0);
      step();
      look("mdu reset no done", '0);
      step();

      reset = 1'b1;
      step();
      reset = 1'b0;
      m_busy = 0; m_drain = 0; m_halted = 1'b0; m_pend = 1'b0; hreq = 1'b0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         bus.Rs1D = 5'($urandom_range(0, 3));  bus.Rs2D = 5'($urandom_range(0, 3));
         bus.Rs1E = 5'($urandom_range(0, 3));  bus.Rs2E = 5'($urandom_range(0, 3));
         bus.RdE  = 5'($urandom_range(0, 3));  bus.RdM  = 5'($urandom_range(0, 3));
         bus.RdW  = 5'($urandom_range(0, 3));
         bus.ResultSrcE0 = 1'($urandom_range(0, 1));
         bus.RegWriteM   = 1'($urandom_range(0, 1));
         bus.RegWriteW   = 1'($urandom_range(0, 1));
         bus.MduStartE   = $urandom_range(0, 9) == 0;
         bus.PCSrcE      = !bus.MduStartE && $urandom_range(0, 4) == 0;
         if ($urandom_range(0, 19) == 0) hreq = !hreq;
         bus.halt_req = hreq;
         bus.resume   = $urandom_range(0, 7) == 0;
         reset        = $urandom_range(0, 299) == 0;
         model_cycle(cyc);
         step();
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
